// File: rtl/rob_wb_arbiter_pkg.sv
// Shared definitions for the ROB writeback arbiter: producer source
// encodings and the round-robin successor helper.
package rob_wb_arbiter_pkg;

    localparam int WB_SRC_WIDTH = 2;
    localparam int WB_NUM_SRC   = 3;

    typedef enum logic [WB_SRC_WIDTH-1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_MUL = 2'd2
    } wb_src_e;

    // Next producer in round-robin order, wrapping 2 -> 0.
    function automatic logic [WB_SRC_WIDTH-1:0] rr_next(input logic [WB_SRC_WIDTH-1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/rob_wb_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter: holds the priority pointer, finds the first
// requester at or after the pointer, and advances past the winner on a grant.
module rob_wb_arbiter_rr_arbiter3
    import rob_wb_arbiter_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [WB_NUM_SRC-1:0]   i_req,
    input  logic                    i_advance,
    input  logic                    i_clear,
    output logic [WB_NUM_SRC-1:0]   o_grant,
    output logic [WB_SRC_WIDTH-1:0] o_winner,
    output logic                    o_any
);

    logic [WB_SRC_WIDTH-1:0] r_ptr;
    logic [WB_NUM_SRC-1:0]   w_req_rot;
    logic [WB_SRC_WIDTH:0]   w_sum;
    logic [WB_SRC_WIDTH-1:0] w_offset;

    // Rotate requests so bit 0 is the producer the pointer currently favours.
    always_comb begin
        w_req_rot = i_req;
        case (r_ptr)
            2'd1:    w_req_rot = {i_req[0], i_req[2], i_req[1]};
            2'd2:    w_req_rot = {i_req[1], i_req[0], i_req[2]};
            default: w_req_rot = i_req;
        endcase
    end

    // Fixed-priority pick on the rotated vector, then map back to a producer index.
    always_comb begin
        w_offset = 2'd0;
        o_any    = |w_req_rot;
        if (w_req_rot[0])      w_offset = 2'd0;
        else if (w_req_rot[1]) w_offset = 2'd1;
        else if (w_req_rot[2]) w_offset = 2'd2;
        w_sum    = {1'b0, r_ptr} + {1'b0, w_offset};
        o_winner = (w_sum >= 3'd3) ? 2'(w_sum - 3'd3) : w_sum[WB_SRC_WIDTH-1:0];
    end

    genvar gi;
    generate
        for (gi = 0; gi < WB_NUM_SRC; gi++) begin : g_grant
            assign o_grant[gi] = o_any && (o_winner == 2'(gi));
        end
    endgenerate

    // Pointer moves just past the winner on a taken grant; a flush restarts at ALU.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= 2'd0;
        end else if (i_clear) begin
            r_ptr <= 2'd0;
        end else if (i_advance && o_any) begin
            r_ptr <= rr_next(o_winner);
        end
    end

endmodule

// File: rtl/rob_wb_arbiter.sv
// ROB writeback arbiter: one registered writeback slot shared by the ALU,
// memory and M5 multiplier producers, with per-producer stall back-pressure.
module rob_wb_arbiter
    import rob_wb_arbiter_pkg::*;
#(
    parameter int WORD_SIZE       = 32,
    parameter int ROB_ENTRY_WIDTH = 3
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_flush,
    input  logic                       i_alu_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] i_alu_rob_id,
    input  logic [WORD_SIZE-1:0]       i_alu_result,
    input  logic                       i_mem_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] i_mem_rob_id,
    input  logic [WORD_SIZE-1:0]       i_mem_result,
    input  logic                       i_mul_valid,
    input  logic [ROB_ENTRY_WIDTH-1:0] i_mul_rob_id,
    input  logic [WORD_SIZE-1:0]       i_mul_result,
    output logic                       o_alu_stall,
    output logic                       o_mem_stall,
    output logic                       o_mul_stall,
    input  logic                       i_wb_ready,
    output logic                       o_wb_valid,
    output logic [ROB_ENTRY_WIDTH-1:0] o_wb_rob_id,
    output logic [WORD_SIZE-1:0]       o_wb_result,
    output logic [WB_SRC_WIDTH-1:0]    o_wb_src
);

    logic                       r_wb_valid;
    logic [ROB_ENTRY_WIDTH-1:0] r_wb_rob_id;
    logic [WORD_SIZE-1:0]       r_wb_result;
    logic [WB_SRC_WIDTH-1:0]    r_wb_src;

    logic                       w_load;
    logic [WB_NUM_SRC-1:0]      w_valid;
    logic [WB_NUM_SRC-1:0]      w_grant;
    logic [WB_NUM_SRC-1:0]      w_stall;
    logic [WB_SRC_WIDTH-1:0]    w_winner;
    logic                       w_any;
    logic [ROB_ENTRY_WIDTH-1:0] w_sel_rob_id;
    logic [WORD_SIZE-1:0]       w_sel_result;

    assign w_valid = {i_mul_valid, i_mem_valid, i_alu_valid};
    // Slot can accept a new result when empty or being drained this cycle.
    assign w_load  = !r_wb_valid || i_wb_ready;

    rob_wb_arbiter_rr_arbiter3 u_rr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_req     (w_valid),
        .i_advance (w_load && !i_flush),
        .i_clear   (i_flush),
        .o_grant   (w_grant),
        .o_winner  (w_winner),
        .o_any     (w_any)
    );

    // Route the winning producer's tag and data to the slot input.
    always_comb begin
        w_sel_rob_id = i_alu_rob_id;
        w_sel_result = i_alu_result;
        case (w_winner)
            WB_SRC_MEM: begin
                w_sel_rob_id = i_mem_rob_id;
                w_sel_result = i_mem_result;
            end
            WB_SRC_MUL: begin
                w_sel_rob_id = i_mul_rob_id;
                w_sel_result = i_mul_result;
            end
            default: begin
                w_sel_rob_id = i_alu_rob_id;
                w_sel_result = i_alu_result;
            end
        endcase
    end

    // A valid producer holds unless it is granted into a loading slot;
    // during a flush every producer is being squashed, so nobody holds.
    genvar gi;
    generate
        for (gi = 0; gi < WB_NUM_SRC; gi++) begin : g_stall
            assign w_stall[gi] = !i_flush && w_valid[gi] && !(w_load && w_grant[gi]);
        end
    endgenerate

    assign o_alu_stall = w_stall[0];
    assign o_mem_stall = w_stall[1];
    assign o_mul_stall = w_stall[2];

    // Writeback slot: capture the winner when loading; data is kept on drain/flush.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_valid  <= 1'b0;
            r_wb_rob_id <= '0;
            r_wb_result <= '0;
            r_wb_src    <= WB_SRC_ALU;
        end else if (i_flush) begin
            r_wb_valid  <= 1'b0;
        end else if (w_load) begin
            if (w_any) begin
                r_wb_valid  <= 1'b1;
                r_wb_rob_id <= w_sel_rob_id;
                r_wb_result <= w_sel_result;
                r_wb_src    <= w_winner;
            end else begin
                r_wb_valid  <= 1'b0;
            end
        end
    end

    assign o_wb_valid  = r_wb_valid;
    assign o_wb_rob_id = r_wb_rob_id;
    assign o_wb_result = r_wb_result;
    assign o_wb_src    = r_wb_src;

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Self-checking bench for rob_wb_arbiter: a directed vector table, hand-written
// corner sequences, and randomized traffic against a reference model.
module tb_rob_wb_arbiter;

    localparam int W  = 32;
    localparam int RW = 3;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          wb_ready;
    logic [2:0]    tb_v;
    logic [RW-1:0] tb_id  [3];
    logic [W-1:0]  tb_res [3];
    logic          alu_stall, mem_stall, mul_stall;
    logic          wb_valid;
    logic [RW-1:0] wb_rob_id;
    logic [W-1:0]  wb_result;
    logic [1:0]    wb_src;

    int checks = 0;
    int errors = 0;

    // Reference model state: the writeback slot and the round-robin pointer.
    logic          m_valid;
    logic [RW-1:0] m_id;
    logic [W-1:0]  m_res;
    int            m_src;
    int            m_ptr;

    rob_wb_arbiter #(.WORD_SIZE(W), .ROB_ENTRY_WIDTH(RW)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_alu_valid  (tb_v[0]),
        .i_alu_rob_id (tb_id[0]),
        .i_alu_result (tb_res[0]),
        .i_mem_valid  (tb_v[1]),
        .i_mem_rob_id (tb_id[1]),
        .i_mem_result (tb_res[1]),
        .i_mul_valid  (tb_v[2]),
        .i_mul_rob_id (tb_id[2]),
        .i_mul_result (tb_res[2]),
        .o_alu_stall  (alu_stall),
        .o_mem_stall  (mem_stall),
        .o_mul_stall  (mul_stall),
        .i_wb_ready   (wb_ready),
        .o_wb_valid   (wb_valid),
        .o_wb_rob_id  (wb_rob_id),
        .o_wb_result  (wb_result),
        .o_wb_src     (wb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_id    = '0;
        m_res   = '0;
        m_src   = 0;
        m_ptr   = 0;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        flush    = 1'b0;
        wb_ready = 1'b1;
        tb_v     = 3'b000;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle against the model: called just after a negedge with inputs
    // already set; checks stalls mid-cycle and the slot after the edge.
    task automatic step(output logic [2:0] st);
        logic load;
        int   win;
        int   idx;
        load = !m_valid || wb_ready;
        win  = -1;
        for (int k = 0; k < 3; k++) begin
            idx = (m_ptr + k) % 3;
            if (win < 0 && tb_v[idx]) win = idx;
        end
        for (int i = 0; i < 3; i++)
            st[i] = !flush && tb_v[i] && !(load && win == i);
        #1;
        chk("stall", {29'd0, mul_stall, mem_stall, alu_stall}, {29'd0, st});
        if (flush) begin
            m_valid = 1'b0;
            m_ptr   = 0;
        end else if (load) begin
            if (win >= 0) begin
                m_valid = 1'b1;
                m_id    = tb_id[win];
                m_res   = tb_res[win];
                m_src   = win;
                m_ptr   = (win + 1) % 3;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        chk("wb_valid",  {31'd0, wb_valid}, {31'd0, m_valid});
        chk("wb_rob_id", {29'd0, wb_rob_id}, {29'd0, m_id});
        chk("wb_result", wb_result, m_res);
        chk("wb_src",    {30'd0, wb_src}, W'(m_src));
        $display("txn t=%0t fl=%0b rdy=%0b v=%03b stall=%03b wb_v=%0b src=%0d id=%0d res=%h",
                 $time, flush, wb_ready, tb_v, {mul_stall, mem_stall, alu_stall},
                 wb_valid, wb_src, wb_rob_id, wb_result);
        @(negedge clk);
    endtask

    typedef struct {
        logic       flush;
        logic       ready;
        logic [2:0] v;
        logic [2:0] st;
        logic       wbv;
        logic [1:0] src;
    } vec_t;

    function automatic vec_t mk(input logic f, input logic r, input logic [2:0] v,
                                input logic [2:0] st, input logic wbv, input logic [1:0] src);
        vec_t x;
        x.flush = f; x.ready = r; x.v = v; x.st = st; x.wbv = wbv; x.src = src;
        return x;
    endfunction

    vec_t tbl [16];

    initial begin
        logic [2:0]    st;
        logic [2:0]    prev_st;
        logic [RW-1:0] exp_id  [3];
        logic [W-1:0]  exp_res [3];

        // Directed table, starting from reset: ids ALU 3, MEM 5, MUL 6.
        tbl[0]  = mk(1'b0, 1'b1, 3'b111, 3'b110, 1'b1, 2'd0);
        tbl[1]  = mk(1'b0, 1'b1, 3'b111, 3'b101, 1'b1, 2'd1);
        tbl[2]  = mk(1'b0, 1'b1, 3'b111, 3'b011, 1'b1, 2'd2);
        tbl[3]  = mk(1'b0, 1'b1, 3'b111, 3'b110, 1'b1, 2'd0);
        tbl[4]  = mk(1'b0, 1'b1, 3'b111, 3'b101, 1'b1, 2'd1);
        tbl[5]  = mk(1'b0, 1'b1, 3'b111, 3'b011, 1'b1, 2'd2);
        tbl[6]  = mk(1'b0, 1'b0, 3'b001, 3'b001, 1'b1, 2'd2);
        tbl[7]  = mk(1'b0, 1'b0, 3'b010, 3'b010, 1'b1, 2'd2);
        tbl[8]  = mk(1'b0, 1'b1, 3'b010, 3'b000, 1'b1, 2'd1);
        tbl[9]  = mk(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, 2'd1);
        tbl[10] = mk(1'b0, 1'b1, 3'b011, 3'b010, 1'b1, 2'd0);
        tbl[11] = mk(1'b0, 1'b0, 3'b101, 3'b101, 1'b1, 2'd0);
        tbl[12] = mk(1'b1, 1'b0, 3'b101, 3'b000, 1'b0, 2'd0);
        tbl[13] = mk(1'b0, 1'b1, 3'b101, 3'b100, 1'b1, 2'd0);
        tbl[14] = mk(1'b0, 1'b0, 3'b100, 3'b100, 1'b1, 2'd0);
        tbl[15] = mk(1'b0, 1'b1, 3'b100, 3'b000, 1'b1, 2'd2);

        exp_id[0] = 3'd3; exp_id[1] = 3'd5; exp_id[2] = 3'd6;
        for (int i = 0; i < 3; i++) begin
            exp_res[i] = 32'h100 + W'(exp_id[i]);
            tb_id[i]   = exp_id[i];
            tb_res[i]  = exp_res[i];
        end

        do_reset();
        #1;
        chk("reset wb_valid",  {31'd0, wb_valid}, 32'd0);
        chk("reset wb_rob_id", {29'd0, wb_rob_id}, 32'd0);
        chk("reset wb_src",    {30'd0, wb_src}, 32'd0);
        @(negedge clk);

        for (int r = 0; r < 16; r++) begin
            flush    = tbl[r].flush;
            wb_ready = tbl[r].ready;
            tb_v     = tbl[r].v;
            #1;
            chk("tbl stall", {29'd0, mul_stall, mem_stall, alu_stall}, {29'd0, tbl[r].st});
            @(posedge clk);
            #1;
            chk("tbl wb_valid",  {31'd0, wb_valid}, {31'd0, tbl[r].wbv});
            chk("tbl wb_src",    {30'd0, wb_src}, {30'd0, tbl[r].src});
            chk("tbl wb_rob_id", {29'd0, wb_rob_id}, {29'd0, exp_id[tbl[r].src]});
            chk("tbl wb_result", wb_result, exp_res[tbl[r].src]);
            $display("txn row=%0d fl=%0b rdy=%0b v=%03b stall=%03b wb_v=%0b src=%0d id=%0d",
                     r, flush, wb_ready, tb_v, tbl[r].st, wb_valid, wb_src, wb_rob_id);
            @(negedge clk);
        end

        // Reset in the middle of traffic, asserted between edges.
        do_reset();
        flush = 1'b0; wb_ready = 1'b1; tb_v = 3'b111;
        tb_id[0] = 3'd1; tb_id[1] = 3'd2; tb_id[2] = 3'd4;
        tb_res[0] = 32'hAAAA0001; tb_res[1] = 32'hBBBB0002; tb_res[2] = 32'hCCCC0004;
        step(st);
        step(st);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset wb_valid",  {31'd0, wb_valid}, 32'd0);
        chk("async reset wb_rob_id", {29'd0, wb_rob_id}, 32'd0);
        chk("async reset wb_result", wb_result, 32'd0);
        chk("async reset wb_src",    {30'd0, wb_src}, 32'd0);
        chk("async reset stalls", {29'd0, mul_stall, mem_stall, alu_stall}, 32'd6);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(st);
        chk("post-reset winner src", {30'd0, wb_src}, 32'd0);
        chk("post-reset winner id",  {29'd0, wb_rob_id}, 32'd1);

        // MUL alone, four back-to-back writebacks.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tb_v      = 3'b100;
            tb_id[2]  = RW'(2 + i);
            tb_res[2] = 32'h10 + i;
            step(st);
            chk("mul burst src", {30'd0, wb_src}, 32'd2);
            chk("mul burst id",  {29'd0, wb_rob_id}, 32'(2 + i));
            chk("mul burst res", wb_result, 32'h10 + i);
        end
        tb_v = 3'b000;
        step(st);

        // Randomized traffic; stalled producers hold their request.
        do_reset();
        prev_st = 3'b000;
        for (int n = 0; n < 400; n++) begin
            flush    = ($urandom_range(0, 19) == 0);
            wb_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 3; i++) begin
                if (!prev_st[i]) begin
                    tb_v[i]   = ($urandom_range(0, 1) == 1);
                    tb_id[i]  = RW'($urandom);
                    tb_res[i] = $urandom;
                end
            end
            step(st);
            prev_st = st;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected end before 200000");
        $fatal(1, "timeout");
    end

endmodule
